// File: rtl/hilo_fwd_unit_pkg.sv
// Shared encodings for the HI/LO forwarding unit: stall-bus levels and the
// output-register action selector.
package hilo_fwd_unit_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        OUT_FLUSH  = 2'd0,
        OUT_BUBBLE = 2'd1,
        OUT_LOAD   = 2'd2,
        OUT_HOLD   = 2'd3
    } out_sel_e;

    // A stalled consumer whose successor keeps moving must emit a bubble.
    function automatic out_sel_e out_sel(input logic flush, input logic st_cur,
                                         input logic st_nxt);
        if (flush)
            return OUT_FLUSH;
        else if (st_cur == STOP && st_nxt == NO_STOP)
            return OUT_BUBBLE;
        else if (st_cur == NO_STOP)
            return OUT_LOAD;
        else
            return OUT_HOLD;
    endfunction

endpackage

// File: rtl/hilo_fwd_mux.sv
// Priority mux: youngest in-flight stage first, then the commit port, then the
// architectural register.
module hilo_fwd_mux #(
    parameter int DW     = 32,
    parameter int NSTAGE = 3
) (
    input  logic [NSTAGE-1:0]    fwd_we,
    input  logic [NSTAGE*DW-1:0] fwd_d,
    input  logic                 wb_we,
    input  logic [DW-1:0]        wb_d,
    input  logic [DW-1:0]        arch_d,
    output logic [DW-1:0]        res
);

    // Walk oldest to youngest so stage 0 overwrites last and wins.
    always_comb begin
        res = wb_we ? wb_d : arch_d;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (fwd_we[k])
                res = fwd_d[k*DW +: DW];
        end
    end

endmodule

// File: rtl/hilo_fwd_unit.sv
// HI/LO register unit: architectural pair, forwarding resolve, registered
// consumer output and a multi-cycle writer scoreboard with hazard stall.
module hilo_fwd_unit
    import hilo_fwd_unit_pkg::*;
#(
    parameter int DW        = 32,
    parameter int NSTAGE    = 3,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = 3,
    parameter int MAXPEND   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [NSTAGE-1:0]    fwd_hi_we,
    input  logic [NSTAGE-1:0]    fwd_lo_we,
    input  logic [NSTAGE*DW-1:0] fwd_hi_i,
    input  logic [NSTAGE*DW-1:0] fwd_lo_i,
    input  logic                 wb_hi_we,
    input  logic                 wb_lo_we,
    input  logic [DW-1:0]        wb_hi_i,
    input  logic [DW-1:0]        wb_lo_i,
    input  logic                 md_start,
    input  logic                 md_done,
    input  logic                 rd_hilo,
    output logic                 stallreq,
    output logic [DW-1:0]        hi_o,
    output logic [DW-1:0]        lo_o,
    output logic                 err_o
);

    localparam int CW = $clog2(MAXPEND + 1);

    logic [DW-1:0] hi_r_q, hi_r_d, lo_r_q, lo_r_d;
    logic [DW-1:0] hi_o_q, hi_o_d, lo_o_q, lo_o_d;
    logic [CW-1:0] pend_q, pend_d;
    logic          err_q, err_d;
    logic [DW-1:0] hi_res, lo_res;
    out_sel_e      sel;

    logic unused_stall;
    assign unused_stall = ^stall;

    hilo_fwd_mux #(.DW(DW), .NSTAGE(NSTAGE)) u_hi_mux (
        .fwd_we (fwd_hi_we),
        .fwd_d  (fwd_hi_i),
        .wb_we  (wb_hi_we),
        .wb_d   (wb_hi_i),
        .arch_d (hi_r_q),
        .res    (hi_res)
    );

    hilo_fwd_mux #(.DW(DW), .NSTAGE(NSTAGE)) u_lo_mux (
        .fwd_we (fwd_lo_we),
        .fwd_d  (fwd_lo_i),
        .wb_we  (wb_lo_we),
        .wb_d   (wb_lo_i),
        .arch_d (lo_r_q),
        .res    (lo_res)
    );

    assign sel = out_sel(flush, stall[STALL_IDX], stall[STALL_IDX+1]);

    always_comb begin
        hi_r_d = wb_hi_we ? wb_hi_i : hi_r_q;
        lo_r_d = wb_lo_we ? wb_lo_i : lo_r_q;
        hi_o_d = hi_o_q;
        lo_o_d = lo_o_q;
        case (sel)
            OUT_FLUSH, OUT_BUBBLE: begin
                hi_o_d = '0;
                lo_o_d = '0;
            end
            OUT_LOAD: begin
                hi_o_d = hi_res;
                lo_o_d = lo_res;
            end
            default: ;
        endcase
    end

    // Over/underflow saturate and latch a sticky error; flush wins outright.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (flush) begin
            pend_d = '0;
        end else if (md_start && !md_done) begin
            if (pend_q == CW'(MAXPEND))
                err_d = 1'b1;
            else
                pend_d = pend_q + 1'b1;
        end else if (md_done && !md_start) begin
            if (pend_q == '0)
                err_d = 1'b1;
            else
                pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r_q <= '0;
            lo_r_q <= '0;
            hi_o_q <= '0;
            lo_o_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            hi_r_q <= hi_r_d;
            lo_r_q <= lo_r_d;
            hi_o_q <= hi_o_d;
            lo_o_q <= lo_o_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // A completing writer is already on the forward ports, so it no longer blocks.
    assign stallreq = rd_hilo && (pend_q > CW'(md_done));
    assign hi_o     = hi_o_q;
    assign lo_o     = lo_o_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_hilo_fwd_unit.sv
// Scoreboard bench for hilo_fwd_unit: a driver pushes model expectations, a
// negedge monitor pops and compares them against the DUT.
module tb_hilo_fwd_unit;

    localparam int DW = 32, NS = 3, SW = 6, SI = 3, MP = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [SW-1:0]    stall = '0;
    logic             flush = 1'b0;
    logic [NS-1:0]    fwd_hi_we = '0, fwd_lo_we = '0;
    logic [NS*DW-1:0] fwd_hi_i = '0, fwd_lo_i = '0;
    logic             wb_hi_we = 1'b0, wb_lo_we = 1'b0;
    logic [DW-1:0]    wb_hi_i = '0, wb_lo_i = '0;
    logic             md_start = 1'b0, md_done = 1'b0, rd_hilo = 1'b0;
    logic             stallreq, err_o;
    logic [DW-1:0]    hi_o, lo_o;

    hilo_fwd_unit #(.DW(DW), .NSTAGE(NS), .STALL_W(SW), .STALL_IDX(SI), .MAXPEND(MP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .fwd_hi_we(fwd_hi_we), .fwd_lo_we(fwd_lo_we), .fwd_hi_i(fwd_hi_i), .fwd_lo_i(fwd_lo_i),
        .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .md_start(md_start), .md_done(md_done), .rd_hilo(rd_hilo),
        .stallreq(stallreq), .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] stall; logic flush;
        logic [NS-1:0] fhw, flw; logic [NS*DW-1:0] fhi, flo;
        logic whw, wlw; logic [DW-1:0] whi, wlo;
        logic start, done, rd;
    } stim_t;

    typedef struct { logic [DW-1:0] hi, lo; logic st, err; } exp_t;

    exp_t q[$];
    int n_tests = 0, n_fail = 0;

    // reference state
    logic [DW-1:0] m_hi_r, m_lo_r, m_hi_o, m_lo_o;
    int            m_pend;
    logic          m_err;

    function automatic stim_t idle();
        stim_t s;
        s.stall = '0; s.flush = 0; s.fhw = '0; s.flw = '0; s.fhi = '0; s.flo = '0;
        s.whw = 0; s.wlw = 0; s.whi = '0; s.wlo = '0; s.start = 0; s.done = 0; s.rd = 0;
        return s;
    endfunction

    function automatic logic [DW-1:0] pick(input logic [NS-1:0] we, input logic [NS*DW-1:0] d,
                                           input logic wwe, input logic [DW-1:0] wd,
                                           input logic [DW-1:0] arch);
        for (int k = 0; k < NS; k++)
            if (we[k]) return d[k*DW +: DW];
        return wwe ? wd : arch;
    endfunction

    task automatic model_reset();
        m_hi_r = '0; m_lo_r = '0; m_hi_o = '0; m_lo_o = '0; m_pend = 0; m_err = 0;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        logic [DW-1:0] rh, rl;
        @(posedge clk); #1;
        stall = s.stall; flush = s.flush; fwd_hi_we = s.fhw; fwd_lo_we = s.flw;
        fwd_hi_i = s.fhi; fwd_lo_i = s.flo; wb_hi_we = s.whw; wb_lo_we = s.wlw;
        wb_hi_i = s.whi; wb_lo_i = s.wlo; md_start = s.start; md_done = s.done; rd_hilo = s.rd;
        e.hi = m_hi_o; e.lo = m_lo_o; e.err = m_err;
        e.st = s.rd && (m_pend - (s.done ? 1 : 0) > 0);
        q.push_back(e);
        rh = pick(s.fhw, s.fhi, s.whw, s.whi, m_hi_r);
        rl = pick(s.flw, s.flo, s.wlw, s.wlo, m_lo_r);
        if (s.flush || (s.stall[SI] && !s.stall[SI+1])) begin
            m_hi_o = '0; m_lo_o = '0;
        end else if (!s.stall[SI]) begin
            m_hi_o = rh; m_lo_o = rl;
        end
        if (s.whw) m_hi_r = s.whi;
        if (s.wlw) m_lo_r = s.wlo;
        if (s.flush) m_pend = 0;
        else if (s.start && !s.done) begin
            if (m_pend == MP) m_err = 1; else m_pend++;
        end else if (s.done && !s.start) begin
            if (m_pend == 0) m_err = 1; else m_pend--;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("hi_o", hi_o, e.hi);
            check("lo_o", lo_o, e.lo);
            check("stallreq", {31'b0, stallreq}, {31'b0, e.st});
            check("err_o", {31'b0, err_o}, {31'b0, e.err});
        end
    end

    initial begin
        stim_t s;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // forward priority over wb, then the committed value
        s = idle(); s.fhw = 3'b110; s.fhi = {32'h22, 32'h11, 32'h0};
        s.whw = 1; s.whi = 32'h33; step(s);
        step(idle());
        step(idle());

        // HI from youngest stage, LO from commit
        s = idle(); s.fhw = 3'b001; s.fhi = {64'h0, 32'hAAAA}; s.wlw = 1; s.wlo = 32'h5555; step(s);
        step(idle());

        // hold, bubble, reload, flush
        s = idle(); s.fhw = 3'b001; s.fhi = {64'h0, 32'hDEAD}; s.stall = 6'b011000; step(s);
        s.stall = 6'b001000; step(s);
        s.stall = 6'b000000; step(s);
        s.flush = 1; step(s);
        step(idle());

        // scoreboard: two starts, done at 2 keeps stall, done at 1 releases
        s = idle(); s.rd = 1; s.start = 1; step(s); step(s);
        s.start = 0; step(s);
        s.done = 1; step(s);
        step(s);
        s.done = 0; s.start = 1; step(s); step(s);
        step(s);
        s.start = 0; step(s);

        // async reset with pend=2 and err set
        @(negedge clk); #2;
        rd_hilo = 1; stall = '0; flush = 0; fwd_hi_we = '0; fwd_lo_we = '0;
        wb_hi_we = 0; wb_lo_we = 0; md_start = 0; md_done = 0;
        rst_n = 1'b0; #1;
        check("rst_hi_o", hi_o, '0);
        check("rst_lo_o", lo_o, '0);
        check("rst_err_o", {31'b0, err_o}, '0);
        check("rst_stallreq", {31'b0, stallreq}, '0);
        model_reset();
        @(posedge clk); #2 rst_n = 1'b1;

        // flush beats a same-cycle start; arch reg survives flush
        s = idle(); s.whw = 1; s.whi = 32'h1234_5678; s.rd = 1; s.start = 1; step(s);
        s = idle(); s.rd = 1; s.start = 1; s.flush = 1; step(s);
        s = idle(); s.rd = 1; step(s);
        step(s);

        for (int i = 0; i < 1500; i++) begin
            s.stall = 6'($urandom); s.flush = ($urandom_range(0, 15) == 0);
            s.fhw = 3'($urandom) & 3'($urandom); s.flw = 3'($urandom) & 3'($urandom);
            s.fhi = {$urandom, $urandom, $urandom}; s.flo = {$urandom, $urandom, $urandom};
            s.whw = 1'($urandom); s.wlw = 1'($urandom); s.whi = $urandom; s.wlo = $urandom;
            s.start = ($urandom_range(0, 3) == 0); s.done = ($urandom_range(0, 3) == 0);
            s.rd = 1'($urandom);
            step(s);
        end
        step(idle());

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
